// File: rtl/path_replayer.sv
// path_replayer: drains a solver move stack into a local buffer, then replays
// the moves to a valid/ready consumer in their original push order.
module path_replayer #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          stk_empty,
    input  logic [1:0]    stk_data,
    output logic          stk_pop,
    output logic          move_valid,
    output logic [1:0]    move,
    input  logic          move_ready,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_PLAY  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t          r_state;
    logic [AW:0]     r_count;
    logic [AW-1:0]   r_rd_idx;
    logic [1:0]      r_move;
    logic            r_move_valid;
    logic            r_busy;
    logic            r_done;
    logic [1:0]      r_buf [DEPTH];

    logic            w_pop;
    logic [AW-1:0]   w_wr_idx;
    logic [AW-1:0]   w_exit_idx;
    logic [AW-1:0]   w_next_idx;

    // Pop request and buffer index arithmetic; the pop is deliberately
    // combinational so one stack entry moves per cycle without bubbles.
    always_comb begin
        w_pop      = 1'b0;
        w_wr_idx   = r_count[AW-1:0];
        // count==DEPTH wraps the low bits to 0, so count-1 still lands on DEPTH-1
        w_exit_idx = r_count[AW-1:0] - AW'(1);
        w_next_idx = r_rd_idx - AW'(1);
        if (r_state == S_DRAIN) begin
            w_pop = (~stk_empty) && (r_count < DEPTH_C);
        end else begin
            w_pop = 1'b0;
        end
    end

    // Capture buffer: buf[0] receives the top of stack (latest move); no reset,
    // stale contents are unreachable because count clears on every new run.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_buf[w_wr_idx] <= stk_data;
        end
    end

    // Replay FSM with registered move/valid/busy/done outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_rd_idx     <= '0;
            r_move       <= 2'b00;
            r_move_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (run) begin
                        r_state <= S_DRAIN;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_pop) begin
                        r_count <= r_count + (AW+1)'(1);
                    end else if (r_count != '0) begin
                        r_state      <= S_PLAY;
                        r_rd_idx     <= w_exit_idx;
                        r_move       <= r_buf[w_exit_idx];
                        r_move_valid <= 1'b1;
                    end else begin
                        // nothing captured: skip straight to completion
                        r_state <= S_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (move_ready) begin
                        if (r_rd_idx == '0) begin
                            r_state      <= S_FIN;
                            r_move_valid <= 1'b0;
                            r_move       <= 2'b00;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                        end else begin
                            r_rd_idx <= w_next_idx;
                            r_move   <= r_buf[w_next_idx];
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_move_valid <= 1'b0;
                    r_move       <= 2'b00;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b0;
                end
            endcase
        end
    end

    assign stk_pop    = w_pop;
    assign move_valid = r_move_valid;
    assign move       = r_move;
    assign busy       = r_busy;
    assign done       = r_done;
    assign count      = r_count;

endmodule

// File: tb/tb_path_replayer.sv
// Scoreboard bench for path_replayer: a behavioural stack feeds the DUT,
// expected moves are queued at push time and a negedge monitor checks them.
module tb_path_replayer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        stk_empty;
    logic [1:0]  stk_data;
    logic        stk_pop;
    logic        move_valid;
    logic [1:0]  move;
    logic        move_ready;
    logic        busy;
    logic        done;
    logic [8:0]  count;

    int total = 0;
    int bad = 0;
    int pops = 0;
    int dones = 0;
    int accepted = 0;
    int pushed = 0;
    int popped = 0;
    int stall_left = 0;
    int stall_at = -1;
    bit hold_pending = 1'b0;
    logic [1:0] hold_move = 2'b00;

    logic [1:0] smem [0:511];
    logic [1:0] exp_q [$];
    logic [1:0] full_vals [0:257];

    path_replayer #(.DEPTH(256), .AW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .stk_empty  (stk_empty),
        .stk_data   (stk_data),
        .stk_pop    (stk_pop),
        .move_valid (move_valid),
        .move       (move),
        .move_ready (move_ready),
        .busy       (busy),
        .done       (done),
        .count      (count)
    );

    always #5 clk = ~clk;

    // behavioural solver stack: top is the most recent push
    assign stk_empty = ((pushed - popped) == 0);
    assign stk_data  = ((pushed - popped) > 0) ? smem[pushed - popped - 1] : 2'b00;

    always @(posedge clk) begin
        if (stk_pop) popped <= popped + 1;
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%0d req=%0d", name, act, req);
        end
    endtask

    task automatic push(input logic [1:0] v, input bit expect_it);
        smem[pushed - popped] = v;
        pushed++;
        if (expect_it) exp_q.push_back(v);
    endtask

    // monitor: scoreboard pops on every handshake, hold stability on stalls
    always @(negedge clk) begin
        logic [1:0] e;
        if (rst) begin
            if (stk_pop) pops++;
            if (done) dones++;
            if (hold_pending) begin
                check("hold_valid", move_valid, 1);
                check("hold_move", move, hold_move);
            end
            if (move_valid && move_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_move act=%0d req=none", move);
                end else begin
                    e = exp_q.pop_front();
                    check("move", move, e);
                end
                accepted++;
            end
            hold_pending = move_valid && !move_ready;
            hold_move    = move;
        end else begin
            hold_pending = 1'b0;
        end
    end

    // consumer ready driver: optional stall once a given number of moves accepted
    initial begin
        move_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0 && accepted == stall_at) begin
                move_ready = 1'b0;
                stall_left--;
            end else begin
                move_ready = 1'b1;
            end
        end
    end

    task automatic run_replay(input int budget, input int rerun_at,
                              output int first_v, output int done_at);
        run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        first_v = -1;
        done_at = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            run = (k == rerun_at);
            if (move_valid && first_v < 0) first_v = k;
            if (done) begin
                done_at = k;
                break;
            end
        end
        run = 1'b0;
        if (done_at < 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout act=none req=done_within_%0d", budget);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fv, da, p0, d0, a0;
        rst = 1'b0;
        run = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_stk_pop", stk_pop, 0);
        check("rst_move_valid", move_valid, 0);
        check("rst_move", move, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        // four-move path, free-running consumer
        push(2'b11, 1'b1); push(2'b00, 1'b1); push(2'b01, 1'b1); push(2'b10, 1'b1);
        p0 = pops; d0 = dones; a0 = accepted;
        run_replay(50, -1, fv, da);
        check("a_pops", pops - p0, 4);
        check("a_moves", accepted - a0, 4);
        check("a_count", count, 4);
        check("a_dones", dones - d0, 1);
        check("a_first_valid_cycle", fv, 6);
        check("a_done_cycle", da, 10);
        check("a_queue_left", exp_q.size(), 0);
        check("a_busy_idle", busy, 0);

        // empty stack
        p0 = pops; d0 = dones; a0 = accepted;
        run_replay(10, -1, fv, da);
        check("b_pops", pops - p0, 0);
        check("b_no_valid", fv, -1);
        check("b_count", count, 0);
        check("b_done_le3", int'(da >= 1 && da <= 3), 1);
        check("b_dones", dones - d0, 1);

        // three moves, 5-cycle stall on the second, rerun pulse during play
        push(2'b01, 1'b1); push(2'b10, 1'b1); push(2'b11, 1'b1);
        p0 = pops; d0 = dones; a0 = accepted;
        stall_at = accepted + 1;
        stall_left = 5;
        run_replay(60, 7, fv, da);
        check("c_moves", accepted - a0, 3);
        check("c_pops", pops - p0, 3);
        check("c_first_valid_cycle", fv, 5);
        check("c_done_cycle", da, 13);
        check("c_dones_single", dones - d0, 1);
        check("c_count", count, 3);
        check("c_busy_after", busy, 0);
        check("c_queue_left", exp_q.size(), 0);
        stall_left = 0;
        stall_at = -1;

        // full stack of 256
        for (int i = 0; i < 256; i++) push(2'($urandom_range(0, 3)), 1'b1);
        p0 = pops; d0 = dones; a0 = accepted;
        run_replay(700, -1, fv, da);
        check("d_pops", pops - p0, 256);
        check("d_moves", accepted - a0, 256);
        check("d_count", count, 256);
        check("d_first_valid_cycle", fv, 258);
        check("d_stk_empty", stk_empty, 1);
        check("d_dones", dones - d0, 1);
        check("d_queue_left", exp_q.size(), 0);

        // 258 entries: two stay in the stack; reset mid-play, then replay the rest
        for (int i = 0; i < 258; i++) begin
            full_vals[i] = 2'($urandom_range(0, 3));
            push(full_vals[i], (i >= 2));
        end
        a0 = accepted;
        run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        fv = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (accepted - a0 >= 5) begin
                fv = 1;
                break;
            end
        end
        if (fv == 0) begin
            total++;
            bad++;
            $display("FAIL e_play_timeout act=%0d req=5", accepted - a0);
        end
        #2;
        check("e_count_full", count, 256);
        check("e_left_in_stack", pushed - popped, 2);
        check("e_busy_before_rst", busy, 1);
        rst = 1'b0;
        #1;
        check("e_rst_valid", move_valid, 0);
        check("e_rst_busy", busy, 0);
        check("e_rst_pop", stk_pop, 0);
        check("e_rst_count", count, 0);
        check("e_rst_move", move, 0);
        exp_q.delete();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("e_idle_no_pop", stk_pop, 0);
        check("e_idle_no_valid", move_valid, 0);
        @(posedge clk);
        #1;
        exp_q.push_back(full_vals[0]);
        exp_q.push_back(full_vals[1]);
        p0 = pops; a0 = accepted;
        run_replay(20, -1, fv, da);
        check("e_pops", pops - p0, 2);
        check("e_moves", accepted - a0, 2);
        check("e_count", count, 2);
        check("e_first_valid_cycle", fv, 4);
        check("e_stk_empty", stk_empty, 1);
        check("e_queue_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
